// File: rtl/modn_updown_counter_if.sv
// ----------------------------------------------------------------------------
// modn_updown_counter_if
//   Control and status bundle for the modulo-MOD up/down counter.
//   master : the side that drives controls (SCLR, LC, EN, UP, OS, I) and
//            observes status (Q, TC, CO, DONE, LERR).
//   slave  : the counter itself.
//   WIDTH must match the WIDTH of the counter instance it is connected to.
// ----------------------------------------------------------------------------
interface modn_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             SCLR;  // synchronous clear, active-high
  logic             LC;    // 1 = load I, 0 = count
  logic             EN;    // count enable
  logic             UP;    // 1 = up, 0 = down
  logic             OS;    // 1 = one-shot, 0 = free-running wrap
  logic [WIDTH-1:0] I;     // parallel load value
  logic [WIDTH-1:0] Q;     // registered count
  logic             TC;    // combinational terminal count
  logic             CO;    // registered carry/borrow pulse
  logic             DONE;  // registered one-shot complete flag
  logic             LERR;  // sticky out-of-range load flag

  modport master (
    output SCLR, LC, EN, UP, OS, I,
    input  Q, TC, CO, DONE, LERR
  );

  modport slave (
    input  SCLR, LC, EN, UP, OS, I,
    output Q, TC, CO, DONE, LERR
  );
endinterface

// File: rtl/modn_updown_counter.sv
// ----------------------------------------------------------------------------
// modn_updown_counter
//   Loadable modulo-MOD up/down counter, cascadable as a divider/sequencer.
//   Count range is 0..MOD-1 in either direction, with free-running wrap or
//   one-shot stop at the terminal value, a one-cycle carry/borrow pulse,
//   and a sticky flag for loads outside the legal range.
//
// Ports
//   CLK  : rising-edge clock
//   CLR  : asynchronous active-low reset (clears Q, CO, DONE, LERR)
//   bus  : slave side of modn_updown_counter_if
//            SCLR, LC, EN, UP, OS, I  -> controls / load value
//            Q, CO, DONE, LERR        <- registered status
//            TC                       <- combinational terminal count
//
// Parameters
//   The counter is WIDTH bits wide; the modulus must lie in 2..2**WIDTH.
// ----------------------------------------------------------------------------
module modn_updown_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 6
) (
  input  logic                 CLK,
  input  logic                 CLR,
  modn_updown_counter_if.slave bus
);

  generate
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
      $error("modn_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
  // One extra bit so MOD = 2**WIDTH is representable in the range check.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             co_reg, co_next;
  logic             done_reg, done_next;
  logic             lerr_reg, lerr_next;
  logic             at_term;

  // Terminal value depends on the direction sampled this cycle, so a
  // direction flip mid-count is seen immediately.
  assign at_term = bus.UP ? (q_reg == MAX_Q) : (q_reg == '0);

  always_comb begin
    q_next    = q_reg;
    co_next   = 1'b0;
    done_next = done_reg;
    lerr_next = lerr_reg;

    if (bus.SCLR) begin
      q_next    = '0;
      done_next = 1'b0;
      lerr_next = 1'b0;
    end else if (bus.LC) begin
      done_next = 1'b0;
      if ({1'b0, bus.I} < MOD_W) begin
        q_next = bus.I;
      end else begin
        // Saturate rather than load an illegal value, and remember it.
        q_next    = MAX_Q;
        lerr_next = 1'b1;
      end
    end else if (bus.EN && !done_reg) begin
      if (at_term) begin
        co_next = 1'b1;
        if (bus.OS) begin
          done_next = 1'b1;               // Q parks at the terminal value
        end else begin
          q_next = bus.UP ? '0 : MAX_Q;   // explicit wrap keeps Q < MOD
        end
      end else begin
        q_next = bus.UP ? (q_reg + 1'b1) : (q_reg - 1'b1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_reg    <= '0;
      co_reg   <= 1'b0;
      done_reg <= 1'b0;
      lerr_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      co_reg   <= co_next;
      done_reg <= done_next;
      lerr_reg <= lerr_next;
    end
  end

  assign bus.Q    = q_reg;
  assign bus.CO   = co_reg;
  assign bus.DONE = done_reg;
  assign bus.LERR = lerr_reg;
  assign bus.TC   = bus.EN & ~bus.LC & ~bus.SCLR & ~done_reg & at_term;

endmodule
